// File: rtl/geofence_pkg.sv
// Shared types and sizing for the geofence point-in-hexagon sequencer.
// Points are unsigned W-bit coordinates; edge vectors are (W+1)-bit signed.
package geofence_pkg;

  localparam int W   = 10;
  localparam int NAP = 6;
  localparam int NPT = NAP + 1;
  localparam int IW  = $clog2(NPT);

  typedef enum logic [1:0] {LOAD, SORT, TEST, DONE} state_t;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
  } point_t;

  typedef logic signed [W:0] vec_t;

  // Zero-extend both coordinates so the (W+1)-bit difference never overflows.
  function automatic vec_t vdiff(input logic [W-1:0] a, input logic [W-1:0] b);
    return vec_t'({1'b0, a}) - vec_t'({1'b0, b});
  endfunction

endpackage

// File: rtl/fence_ptbuf.sv
// Seven-entry point store: entry 0 is the object, entries 1..6 are AP0..AP5.
// Sequential load port, adjacent-pair swap port, two combinational reads plus fixed object/pivot taps.
module fence_ptbuf
  import geofence_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  point_t        wr_pt,
  input  logic          swap_en,
  input  logic [IW-1:0] swap_idx,
  input  logic [IW-1:0] rd_a_idx,
  input  logic [IW-1:0] rd_b_idx,
  output point_t        rd_a,
  output point_t        rd_b,
  output point_t        obj,
  output point_t        pivot
);

  point_t pts [NPT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NPT; i++) pts[i] <= '0;
    end else if (wr_en) begin
      pts[wr_idx] <= wr_pt;
    end else if (swap_en) begin
      pts[swap_idx]          <= pts[swap_idx + IW'(1)];
      pts[swap_idx + IW'(1)] <= pts[swap_idx];
    end
  end

  assign rd_a  = pts[rd_a_idx];
  assign rd_b  = pts[rd_b_idx];
  assign obj   = pts[0];
  assign pivot = pts[1];

endmodule

// File: rtl/geofence_sched.sv
// Geofence sequencer: load object + 6 APs, bubble-sort APs CCW about AP0, run six edge tests.
// One cross-product in flight at a time; waits indefinitely on cp_ack, one idle cycle between requests.
module geofence_sched
  import geofence_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [W-1:0]        X,
  input  logic [W-1:0]        Y,
  output logic                valid,
  output logic                is_inside,
  output logic                cp_req,
  output logic signed [W:0]   cp_ax,
  output logic signed [W:0]   cp_ay,
  output logic signed [W:0]   cp_bx,
  output logic signed [W:0]   cp_by,
  input  logic                cp_ack,
  input  logic                cp_neg
);

  localparam logic [IW-1:0] ONE     = IW'(1);
  localparam logic [IW-1:0] LD_LAST = IW'(NPT - 1);
  localparam logic [IW-1:0] K_LAST  = IW'(NAP - 1);
  localparam logic [IW-1:0] J_TOP   = IW'(NAP - 2);
  localparam logic [IW-1:0] P_LAST  = IW'(NAP - 3);

  state_t        state, state_nxt;
  logic [IW-1:0] ld_cnt, pass_cnt, pair_j, test_k, test_k1, j_lim;
  logic [IW-1:0] rd_a_idx, rd_b_idx;
  logic          ack_ok, issue, wr_en, swap_en;
  logic          last_pair, sort_last, test_last, result;
  point_t        rd_a, rd_b, obj, pivot;
  logic signed [W:0] op_ax, op_ay, op_bx, op_by;

  // An ack only counts while a request is outstanding.
  assign ack_ok    = cp_req & cp_ack;
  assign j_lim     = J_TOP - pass_cnt;
  assign last_pair = (pair_j == j_lim);
  assign sort_last = last_pair && (pass_cnt == P_LAST);
  assign test_last = (test_k == K_LAST);
  assign test_k1   = test_last ? '0 : test_k + ONE;

  fence_ptbuf u_buf (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_idx   (ld_cnt),
    .wr_pt    ({X, Y}),
    .swap_en  (swap_en),
    .swap_idx (pair_j + ONE),
    .rd_a_idx (rd_a_idx),
    .rd_b_idx (rd_b_idx),
    .rd_a     (rd_a),
    .rd_b     (rd_b),
    .obj      (obj),
    .pivot    (pivot)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    wr_en     = 1'b0;
    swap_en   = 1'b0;
    case (state)
      LOAD: begin
        wr_en = 1'b1;
        if (ld_cnt == LD_LAST) state_nxt = SORT;
      end
      SORT: begin
        issue = !cp_req;
        if (ack_ok) begin
          swap_en = cp_neg;
          if (sort_last) state_nxt = TEST;
        end
      end
      TEST: begin
        issue = !cp_req;
        if (ack_ok && (cp_neg || test_last)) state_nxt = DONE;
      end
      DONE:    state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Buffer entry n+1 holds AP[n]; entry 0 is the object.
  assign rd_a_idx = (state == TEST) ? test_k1 + ONE : pair_j + ONE;
  assign rd_b_idx = (state == TEST) ? test_k + ONE  : pair_j + IW'(2);

  always_comb begin
    if (state == TEST) begin
      op_ax = vdiff(rd_a.x, rd_b.x);
      op_ay = vdiff(rd_a.y, rd_b.y);
      op_bx = vdiff(obj.x, rd_b.x);
      op_by = vdiff(obj.y, rd_b.y);
    end else begin
      op_ax = vdiff(rd_a.x, pivot.x);
      op_ay = vdiff(rd_a.y, pivot.y);
      op_bx = vdiff(rd_b.x, pivot.x);
      op_by = vdiff(rd_b.y, pivot.y);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_cnt    <= '0;
      pass_cnt  <= '0;
      pair_j    <= ONE;
      test_k    <= '0;
      result    <= 1'b0;
      cp_req    <= 1'b0;
      cp_ax     <= '0;
      cp_ay     <= '0;
      cp_bx     <= '0;
      cp_by     <= '0;
      valid     <= 1'b0;
      is_inside <= 1'b0;
    end else begin
      valid <= 1'b0;

      if (state == LOAD) ld_cnt <= (ld_cnt == LD_LAST) ? '0 : ld_cnt + ONE;

      if (issue) begin
        cp_req <= 1'b1;
        cp_ax  <= op_ax;
        cp_ay  <= op_ay;
        cp_bx  <= op_bx;
        cp_by  <= op_by;
      end else if (ack_ok) begin
        cp_req <= 1'b0;
      end

      if (state == SORT && ack_ok) begin
        if (last_pair) begin
          pair_j   <= ONE;
          pass_cnt <= sort_last ? '0 : pass_cnt + ONE;
        end else begin
          pair_j <= pair_j + ONE;
        end
      end

      // A zero cross product is treated as inside, so only a negative result fails.
      if (state == TEST && ack_ok) begin
        if (cp_neg)         result <= 1'b0;
        else if (test_last) result <= 1'b1;
        test_k <= (cp_neg || test_last) ? '0 : test_k + ONE;
      end

      if (state == DONE) begin
        valid     <= 1'b1;
        is_inside <= result;
      end
    end
  end

endmodule

// File: tb/tb_geofence_sched.sv
// Directed bench for geofence_sched with an exact cross-product engine stub of programmable latency.
module tb_geofence_sched;
  import geofence_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [W-1:0]      X = '0;
  logic [W-1:0]      Y = '0;
  logic              valid, is_inside, cp_req, cp_ack, cp_neg;
  logic signed [W:0] cp_ax, cp_ay, cp_bx, cp_by;

  logic stub_ack = 1'b0, stub_neg = 1'b0, spur_ack = 1'b0;
  assign cp_ack = stub_ack | spur_ack;
  assign cp_neg = spur_ack ? 1'b1 : stub_neg;

  int checks = 0, errors = 0;
  int cyc = 0, lat = 1, cnt = 0, prod = 0;
  int req_total = 0, zero_total = 0, stab_err = 0;
  int start = 0, vedge = -1, req_base = 0, zero_base = 0;
  logic signed [W:0] c_ax, c_ay, c_bx, c_by;

  int ccw_x[6] = '{100, 75, 25, 0, 25, 75};
  int ccw_y[6] = '{50, 93, 93, 50, 7, 7};
  int shuf[6]  = '{0, 4, 3, 1, 5, 2};
  int px[7], py[7];

  geofence_sched dut (
    .clk(clk), .reset(reset), .X(X), .Y(Y), .valid(valid), .is_inside(is_inside),
    .cp_req(cp_req), .cp_ax(cp_ax), .cp_ay(cp_ay), .cp_bx(cp_bx), .cp_by(cp_by),
    .cp_ack(cp_ack), .cp_neg(cp_neg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine stub: ack is sampled at the L-th edge after the edge that raised cp_req.
  always @(negedge clk) begin
    if (reset || !cp_req) begin
      cnt = 0;
      stub_ack = 1'b0;
    end else begin
      if (cnt == 0) begin
        req_total++;
        c_ax = cp_ax; c_ay = cp_ay; c_bx = cp_bx; c_by = cp_by;
      end else if (cp_ax !== c_ax || cp_ay !== c_ay || cp_bx !== c_bx || cp_by !== c_by) begin
        stab_err++;
      end
      cnt++;
      if (cnt == lat) begin
        prod = int'(cp_ax) * int'(cp_by) - int'(cp_bx) * int'(cp_ay);
        stub_ack = 1'b1;
        stub_neg = (prod < 0);
        if (prod == 0) zero_total++;
      end else begin
        stub_ack = 1'b0;
      end
    end
  end

  task automatic set_obj(input int ox, input int oy, input bit shuffled);
    px[0] = ox; py[0] = oy;
    for (int i = 0; i < 6; i++) begin
      px[i+1] = shuffled ? ccw_x[shuf[i]] : ccw_x[i];
      py[i+1] = shuffled ? ccw_y[shuf[i]] : ccw_y[i];
    end
  endtask

  // Starts at a negedge; the next rising edge is edge 0.
  task automatic load_obj(input bit chk_fall, input logic prev_inside);
    start = cyc + 1;
    req_base = req_total;
    zero_base = zero_total;
    for (int i = 0; i < 7; i++) begin
      X = W'(px[i]);
      Y = W'(py[i]);
      @(negedge clk);
      if (i == 0 && chk_fall) begin
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL valid_width got %b want 0", valid); end
        checks++;
        if (is_inside !== prev_inside) begin errors++; $display("FAIL inside_hold got %b want %b", is_inside, prev_inside); end
      end
    end
  endtask

  task automatic chk_first_req(input int ax, input int ay, input int bx, input int by);
    @(negedge clk);
    checks++;
    if (cp_req !== 1'b1 || cyc - start != 7) begin
      errors++; $display("FAIL first_req got req=%b edge=%0d want req=1 edge=7", cp_req, cyc - start);
    end
    checks++;
    if (int'(cp_ax) != ax || int'(cp_ay) != ay || int'(cp_bx) != bx || int'(cp_by) != by) begin
      errors++;
      $display("FAIL first_ops got %0d,%0d,%0d,%0d want %0d,%0d,%0d,%0d",
               int'(cp_ax), int'(cp_ay), int'(cp_bx), int'(cp_by), ax, ay, bx, by);
    end
  endtask

  task automatic wait_valid(input int limit);
    vedge = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin vedge = cyc - start; break; end
    end
    checks++;
    if (vedge < 0) begin errors++; $display("FAIL valid_timeout got none want pulse within %0d", limit); end
  endtask

  task automatic chk_result(input string name, input int exp_edge, input logic exp_in, input int exp_req);
    checks++;
    if (vedge != exp_edge) begin errors++; $display("FAIL %s_edge got %0d want %0d", name, vedge, exp_edge); end
    checks++;
    if (is_inside !== exp_in) begin errors++; $display("FAIL %s_inside got %b want %b", name, is_inside, exp_in); end
    checks++;
    if (req_total - req_base != exp_req) begin
      errors++; $display("FAIL %s_reqs got %0d want %0d", name, req_total - req_base, exp_req);
    end
  endtask

  task automatic chk_buf(input string name);
    logic [2*W-1:0] e;
    for (int i = 0; i < 7; i++) begin
      e = (i == 0) ? {W'(px[0]), W'(py[0])} : {W'(ccw_x[i-1]), W'(ccw_y[i-1])};
      checks++;
      if (dut.u_buf.pts[i] !== e) begin
        errors++; $display("FAIL %s_buf%0d got %h want %h", name, i, dut.u_buf.pts[i], e);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({valid, is_inside, cp_req} !== 3'b000) begin
      errors++; $display("FAIL reset_outs got %b want 000", {valid, is_inside, cp_req});
    end
    checks++;
    if ({cp_ax, cp_ay, cp_bx, cp_by} !== '0) begin errors++; $display("FAIL reset_ops got nonzero want 0"); end
    checks++;
    if (dut.u_buf.pts[4] !== '0) begin errors++; $display("FAIL reset_buf got %h want 0", dut.u_buf.pts[4]); end
    reset = 1'b0;
  endtask

  task automatic test_inside_ccw();
    lat = 1;
    set_obj(50, 50, 1'b0);
    load_obj(1'b0, 1'b0);
    chk_first_req(-25, 43, -75, 43);
    wait_valid(200);
    chk_result("ccw", 39, 1'b1, 16);
    chk_buf("ccw");
  endtask

  task automatic test_sort_outside();
    lat = 3;
    set_obj(200, 200, 1'b1);
    load_obj(1'b0, 1'b0);
    chk_first_req(-75, -43, -100, 0);
    wait_valid(400);
    chk_result("shuf", 51, 1'b0, 11);
    chk_buf("shuf");
  endtask

  task automatic test_on_edge();
    lat = 2;
    set_obj(50, 7, 1'b0);
    load_obj(1'b0, 1'b0);
    wait_valid(300);
    chk_result("edge", 55, 1'b1, 16);
    checks++;
    if (zero_total - zero_base < 1) begin errors++; $display("FAIL edge_zero got %0d want >=1", zero_total - zero_base); end
  endtask

  task automatic test_just_outside();
    lat = 2;
    set_obj(50, 6, 1'b0);
    load_obj(1'b0, 1'b1);
    wait_valid(300);
    chk_result("below", 52, 1'b0, 15);
  endtask

  task automatic test_back_to_back();
    lat = 5;
    set_obj(50, 50, 1'b0);
    load_obj(1'b0, 1'b0);
    wait_valid(500);
    chk_result("b2b_a", 103, 1'b1, 16);
    set_obj(200, 200, 1'b0);
    load_obj(1'b1, 1'b1);
    wait_valid(500);
    chk_result("b2b_b", 73, 1'b0, 11);
    chk_buf("b2b_b");
  endtask

  task automatic test_spurious_ack();
    bit seen;
    lat = 2;
    set_obj(50, 50, 1'b0);
    load_obj(1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cp_req === 1'b1) seen = 1'b1;
      else if (seen) break;
    end
    checks++;
    if (!(seen && cp_req === 1'b0)) begin errors++; $display("FAIL spur_gap got req=%b want gap", cp_req); end
    spur_ack = 1'b1;
    @(negedge clk);
    spur_ack = 1'b0;
    wait_valid(300);
    chk_result("spur", 55, 1'b1, 16);
    chk_buf("spur");
  endtask

  task automatic test_reset_mid();
    lat = 4;
    set_obj(50, 50, 1'b0);
    load_obj(1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (cp_req !== 1'b1) begin errors++; $display("FAIL mid_req_pre got %b want 1", cp_req); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (cp_req !== 1'b0) begin errors++; $display("FAIL mid_req_async got %b want 0", cp_req); end
    checks++;
    if (dut.u_buf.pts[1] !== '0 || is_inside !== 1'b0) begin
      errors++; $display("FAIL mid_clear got %h/%b want 0/0", dut.u_buf.pts[1], is_inside);
    end
    @(negedge clk);
    reset = 1'b0;
    lat = 1;
    set_obj(50, 50, 1'b0);
    load_obj(1'b0, 1'b0);
    wait_valid(200);
    chk_result("after_rst", 39, 1'b1, 16);
  endtask

  initial begin
    test_reset();
    test_inside_ccw();
    test_sort_outside();
    test_on_edge();
    test_just_outside();
    test_back_to_back();
    test_spurious_ack();
    test_reset_mid();
    checks++;
    if (stab_err != 0) begin errors++; $display("FAIL op_stable got %0d want 0", stab_err); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
